// File: rtl/sha256_padder.sv
// ---------------------------------------------------------------------------
// sha256_padder
//
// Collects a byte stream into 512-bit blocks and applies SHA-256 message
// padding (0x80 terminator, zero fill, 64-bit big-endian bit length) so the
// compression core only ever sees complete blocks.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   byte_in/_valid/_last    message byte stream; _last marks the final byte
//   byte_ready              high while a byte can be accepted (fill state)
//   block_out               padded block, byte 0 at [511:504]
//   block_valid/_ready      block handshake toward the compression core
//   block_last              block closes the message (qualified by valid)
// ---------------------------------------------------------------------------
module sha256_padder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_OUT,
        S_LEN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t             state_q, state_d;
    logic [511:0]       blk_q, blk_d;
    logic [5:0]         pos_q, pos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pad_pend_q, pad_pend_d;
    logic               len_pend_q, len_pend_d;
    logic               last_q, last_d;

    logic [63:0]        len_w;
    logic [8:0]         bit_off;
    logic [8:0]         bit_hi;
    logic [511:0]       keep_mask;

    // Message length in bits, zero-extended into the 64-bit length field.
    assign len_w   = 64'({cnt_q, 3'b000});
    assign bit_off = {pos_q, 3'b000};
    assign bit_hi  = 9'd511 - bit_off;
    // Ones over the bytes already written (0..pos-1); padding clears the rest.
    assign keep_mask = ~({512{1'b1}} >> bit_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            blk_q      <= '0;
            pos_q      <= '0;
            cnt_q      <= '0;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            pad_pend_q <= pad_pend_d;
            len_pend_q <= len_pend_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        pad_pend_d = pad_pend_q;
        len_pend_d = len_pend_q;
        last_d     = last_q;

        case (state_q)
            S_FILL: begin
                if (byte_valid) begin
                    blk_d[bit_hi -: 8] = byte_in;
                    pos_d = pos_q + 6'd1;   // wraps to 0 after byte 63
                    cnt_d = cnt_q + CNT_ONE;
                    if (pos_q == 6'd63) begin
                        state_d = S_OUT;
                        last_d  = 1'b0;
                        // A final byte that fills the block leaves padding
                        // for a fresh block after this one is taken.
                        if (byte_last) begin
                            pad_pend_d = 1'b1;
                        end
                    end else if (byte_last) begin
                        state_d = S_PAD;
                    end
                end
            end

            S_PAD: begin
                blk_d = (blk_q & keep_mask) | ({8'h80, 504'h0} >> bit_off);
                if (pos_q <= 6'd55) begin
                    blk_d[63:0] = len_w;
                    last_d      = 1'b1;
                end else begin
                    // No room for the length field: it goes in an extra block.
                    len_pend_d = 1'b1;
                    last_d     = 1'b0;
                end
                state_d = S_OUT;
            end

            S_OUT: begin
                if (block_ready) begin
                    blk_d = '0;
                    pos_d = '0;
                    if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        state_d    = S_PAD;
                    end else if (len_pend_q) begin
                        state_d = S_LEN;
                    end else begin
                        state_d = S_FILL;
                        if (last_q) begin
                            cnt_d  = '0;
                            last_d = 1'b0;
                        end
                    end
                end
            end

            S_LEN: begin
                blk_d      = {448'h0, len_w};
                last_d     = 1'b1;
                len_pend_d = 1'b0;
                state_d    = S_OUT;
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign byte_ready  = (state_q == S_FILL);
    assign block_valid = (state_q == S_OUT);
    assign block_last  = (state_q == S_OUT) && last_q;
    assign block_out   = blk_q;

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;

    logic         clk;
    logic         rst_n;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;

    int unsigned n_checks;
    int unsigned n_fail;

    sha256_padder #(
        .CNT_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [511:0] got,
                            input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sends n bytes: start, start+inc, ...; last byte flagged when with_last.
    task automatic send_seq(input int n, input logic [7:0] start,
                            input logic [7:0] inc, input logic with_last);
        logic [7:0] b;
        int t;
        b = start;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_in    = b;
            byte_valid = 1'b1;
            byte_last  = with_last && (i == n - 1);
            t = 0;
            while (!byte_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check_eq("byte_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
            byte_last  = 1'b0;
            b = b + inc;
        end
    endtask

    // Waits for a block with block_ready=1 held and completes the handshake.
    task automatic get_block(output logic [511:0] blk, output logic lst);
        int t;
        t = 0;
        @(negedge clk);
        while (!block_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_eq("block_valid_timeout", 0, 1);
        blk = block_out;
        lst = block_last;
        @(posedge clk);
        #1;
    endtask

    task automatic check_abc(input string tag);
        logic [511:0] blk;
        logic         lst;
        send_seq(3, 8'h61, 8'h01, 1'b1);
        check_eq({tag, "_valid_n1"}, 512'(block_valid), 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_n2"}, 512'(block_valid), 1);
        get_block(blk, lst);
        check_eq({tag, "_block"}, blk, {32'h61626380, 416'h0, 64'h18});
        check_eq({tag, "_last"}, 512'(lst), 1);
        @(negedge clk);
        check_eq({tag, "_valid_after"}, 512'(block_valid), 0);
        check_eq({tag, "_byte_ready_after"}, 512'(byte_ready), 1);
    endtask

    logic [511:0] blk;
    logic         lst;
    logic [511:0] held_blk;
    logic         held_lst;
    int           hs;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        block_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_byte_ready", 512'(byte_ready), 1);
        check_eq("rst_block_valid", 512'(block_valid), 0);
        check_eq("rst_block_last", 512'(block_last), 0);
        check_eq("rst_block_out", block_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // "abc"
        check_abc("abc");

        // 55 zero bytes: padding and length fit in one block
        send_seq(55, 8'h00, 8'h00, 1'b1);
        get_block(blk, lst);
        check_eq("z55_block", blk, {440'h0, 8'h80, 64'h1B8});
        check_eq("z55_last", 512'(lst), 1);

        // 56 bytes 0xAA: length spills into a second block
        send_seq(56, 8'hAA, 8'h00, 1'b1);
        get_block(blk, lst);
        check_eq("aa56_blk1", blk, {{56{8'hAA}}, 8'h80, 56'h0});
        check_eq("aa56_last1", 512'(lst), 0);
        check_eq("aa56_gap_n1", 512'(block_valid), 0);
        @(posedge clk);
        #1;
        check_eq("aa56_gap_n2", 512'(block_valid), 1);
        get_block(blk, lst);
        check_eq("aa56_blk2", blk, {448'h0, 64'h1C0});
        check_eq("aa56_last2", 512'(lst), 1);

        // 64 bytes 0x55: padding block follows a full block
        send_seq(64, 8'h55, 8'h00, 1'b1);
        get_block(blk, lst);
        check_eq("x55_blk1", blk, {64{8'h55}});
        check_eq("x55_last1", 512'(lst), 0);
        get_block(blk, lst);
        check_eq("x55_blk2", blk, {8'h80, 440'h0, 64'h200});
        check_eq("x55_last2", 512'(lst), 1);
        @(negedge clk);
        check_eq("x55_byte_ready", 512'(byte_ready), 1);

        // Backpressure on "abc" with bytes offered while stalled
        block_ready = 1'b0;
        send_seq(3, 8'h61, 8'h01, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_valid", 512'(block_valid), 1);
        held_blk = block_out;
        held_lst = block_last;
        check_eq("bp_held_block", held_blk, {32'h61626380, 416'h0, 64'h18});
        @(negedge clk);
        byte_in    = 8'hEE;
        byte_valid = 1'b1;
        byte_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_stable_block", block_out, held_blk);
            check_eq("bp_stable_last", 512'(block_last), 512'(held_lst));
            check_eq("bp_byte_ready", 512'(byte_ready), 0);
            check_eq("bp_valid_hold", 512'(block_valid), 1);
        end
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        block_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            if (block_valid && block_ready) hs++;
        end
        check_eq("bp_handshakes", 512'(hs), 1);
        @(negedge clk);
        check_eq("bp_byte_ready_after", 512'(byte_ready), 1);
        // Length field proves the offered bytes were not counted
        check_abc("post_bp_abc");

        // Reset mid-message
        send_seq(20, 8'h30, 8'h01, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_byte_ready", 512'(byte_ready), 1);
        check_eq("mid_rst_block_valid", 512'(block_valid), 0);
        check_eq("mid_rst_block_last", 512'(block_last), 0);
        check_eq("mid_rst_block_out", block_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_abc("rst_abc");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
